// File: rtl/graph_mem_arbiter.sv
// Round-robin arbiter that shares one in-order graph_memory read port among NUM_REQ requesters.
// An in-order tag FIFO records the issuer of each read so every returned word reaches its issuer.
`timescale 1ns/1ps
module graph_mem_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MAX_OUT = 4
) (
  input  logic                         clk_in,
  input  logic                         rst_in,
  input  logic [NUM_REQ-1:0]           req_valid_in,
  input  logic [NUM_REQ*ADDR_W-1:0]    req_addr_in,
  output logic [NUM_REQ-1:0]           req_ready_out,
  output logic [NUM_REQ-1:0]           resp_valid_out,
  output logic [DATA_W-1:0]            resp_data_out,
  output logic [ADDR_W-1:0]            mem_req_out,
  output logic                         mem_valid_out,
  input  logic [DATA_W-1:0]            mem_data_in,
  input  logic                         mem_valid_in,
  output logic [$clog2(MAX_OUT):0]     outstanding_out,
  output logic                         err_out
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int PTR_W = $clog2(MAX_OUT);
  localparam int CNT_W = PTR_W + 1;

  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ADDR_W-1:0]  mem_req_q, mem_req_d;
  logic               mem_valid_q, mem_valid_d;
  logic [NUM_REQ-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]  resp_data_q, resp_data_d;
  logic               err_q, err_d;
  logic [IDX_W-1:0]   tag_mem_q [MAX_OUT];

  logic [IDX_W-1:0]   winner;
  logic               found;
  int                 cand;
  logic               full;
  logic               hs;
  logic               pop;
  logic [IDX_W-1:0]   tag_rd;

  // Rotating priority scan starting just after the last granted requester.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    cand   = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(last_grant_q) + 1 + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!found && req_valid_in[IDX_W'(cand)]) begin
        found  = 1'b1;
        winner = IDX_W'(cand);
      end
    end
  end

  // Full blocks the grant even if a pop lands this cycle, keeping mem_valid_in off the grant path.
  assign full   = (count_q == CNT_W'(MAX_OUT));
  assign hs     = found && !full && rst_in;
  assign pop    = mem_valid_in && (count_q != '0);
  assign tag_rd = tag_mem_q[rd_ptr_q];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
    assign req_ready_out[gi] = hs && (winner == IDX_W'(gi));
  end

  always_comb begin
    last_grant_d = last_grant_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    mem_req_d    = mem_req_q;
    mem_valid_d  = hs;
    resp_valid_d = '0;
    resp_data_d  = resp_data_q;
    err_d        = err_q;
    if (hs) begin
      last_grant_d = winner;
      wr_ptr_d     = wr_ptr_q + PTR_W'(1);
      mem_req_d    = req_addr_in[int'(winner)*ADDR_W +: ADDR_W];
    end
    if (pop) begin
      rd_ptr_d             = rd_ptr_q + PTR_W'(1);
      resp_valid_d[tag_rd] = 1'b1;
      resp_data_d          = mem_data_in;
    end
    if (mem_valid_in && !pop) err_d = 1'b1;
    if (hs && !pop)      count_d = count_q + CNT_W'(1);
    else if (!hs && pop) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      mem_req_q    <= '0;
      mem_valid_q  <= 1'b0;
      resp_valid_q <= '0;
      resp_data_q  <= '0;
      err_q        <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      mem_req_q    <= mem_req_d;
      mem_valid_q  <= mem_valid_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      err_q        <= err_d;
    end
  end

  // Tag storage needs no reset: entries are only read between push and pop.
  always_ff @(posedge clk_in) begin
    if (hs) tag_mem_q[wr_ptr_q] <= winner;
  end

  assign resp_valid_out  = resp_valid_q;
  assign resp_data_out   = resp_data_q;
  assign mem_req_out     = mem_req_q;
  assign mem_valid_out   = mem_valid_q;
  assign outstanding_out = count_q;
  assign err_out         = err_q;
endmodule

// File: tb/tb_graph_mem_arbiter.sv
// Randomised and directed bench for graph_mem_arbiter with a fixed-latency in-order memory model
// and a queue-based reference model of grants, tags and responses.
`timescale 1ns/1ps
module tb_graph_mem_arbiter;
  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MO = 4;

  logic            clk_in = 1'b0;
  logic            rst_in = 1'b0;
  logic [N-1:0]    req_valid_in = '0;
  logic [N*AW-1:0] req_addr_in = '0;
  logic [N-1:0]    req_ready_out;
  logic [N-1:0]    resp_valid_out;
  logic [DW-1:0]   resp_data_out;
  logic [AW-1:0]   mem_req_out;
  logic            mem_valid_out;
  logic [DW-1:0]   mem_data_in = '0;
  logic            mem_valid_in = 1'b0;
  logic [2:0]      outstanding_out;
  logic            err_out;

  graph_mem_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .MAX_OUT(MO)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req_valid_in(req_valid_in), .req_addr_in(req_addr_in), .req_ready_out(req_ready_out),
    .resp_valid_out(resp_valid_out), .resp_data_out(resp_data_out),
    .mem_req_out(mem_req_out), .mem_valid_out(mem_valid_out),
    .mem_data_in(mem_data_in), .mem_valid_in(mem_valid_in),
    .outstanding_out(outstanding_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 2;
  logic orphan_req = 1'b0;
  logic [AW-1:0] mq_addr[$];
  int            mq_due[$];

  // Reference model state: tags in flight, last winner, and expected registered outputs.
  int            m_tags[$];
  int            m_last = N - 1;
  logic [N-1:0]  e_rv = '0;
  logic [DW-1:0] e_rd = '0;
  logic [AW-1:0] e_mr = '0;
  logic          e_mv = 1'b0;
  logic          e_err = 1'b0;
  logic [2:0]    e_out = '0;

  function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
    logic [N-1:0] g;
    int i;
    g = '0;
    if (rst_in !== 1'b1 || m_tags.size() >= MO) return g;
    for (int k = 0; k < N; k++) begin
      i = (m_last + 1 + k) % N;
      if (v[i]) begin
        g[i] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a);
    req_valid_in[i] = v;
    req_addr_in[i*AW +: AW] = a;
  endtask

  initial forever begin
    @(posedge clk_in);
    cyc++;
  end

  // In-order memory: each read returns addr+0x100 exactly lat cycles after its strobe.
  initial forever begin
    @(negedge clk_in);
    mem_valid_in = 1'b0;
    if (orphan_req) begin
      mem_valid_in = 1'b1;
      mem_data_in  = $urandom;
      orphan_req   = 1'b0;
    end else if (mq_due.size() > 0 && mq_due[0] == cyc) begin
      mem_valid_in = 1'b1;
      mem_data_in  = mq_addr.pop_front() + 32'h100;
      void'(mq_due.pop_front());
    end
    if (mem_valid_out === 1'b1) begin
      mq_addr.push_back(mem_req_out);
      mq_due.push_back(cyc + lat);
    end
  end

  initial forever begin
    logic [N-1:0] g;
    int w;
    @(posedge clk_in or negedge rst_in);
    if (!rst_in) begin
      m_tags.delete();
      m_last = N - 1;
      e_rv = '0; e_rd = '0; e_mr = '0; e_mv = 1'b0; e_err = 1'b0; e_out = '0;
    end else begin
      g = model_grant(req_valid_in);
      e_rv = '0;
      if (mem_valid_in) begin
        if (m_tags.size() > 0) begin
          w = m_tags.pop_front();
          e_rv = N'(1 << w);
          e_rd = mem_data_in;
        end else begin
          e_err = 1'b1;
        end
      end
      e_mv = (g != '0);
      if (g != '0) begin
        for (int i = 0; i < N; i++) if (g[i]) w = i;
        m_tags.push_back(w);
        e_mr = req_addr_in[w*AW +: AW];
        m_last = w;
      end
      e_out = 3'(m_tags.size());
    end
  end

  task automatic test_reset();
    req_valid_in = '1;
    req_addr_in  = {$urandom, $urandom, $urandom, $urandom};
    repeat (2) @(negedge clk_in);
    #1;
    checks++;
    if ({req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out, outstanding_out, err_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ready=%b resp_v=%b data=%h mreq=%h mv=%b out=%0d err=%b, want all 0",
               req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out, outstanding_out, err_out);
    end
    rst_in = 1'b1;
    req_valid_in = '0;
  endtask

  task automatic test_fairness();
    logic [N-1:0] g;
    int gcount = 0;
    int idx;
    lat = 2;
    for (int c = 0; c < 28; c++) begin
      @(negedge clk_in);
      checks++;
      if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
        $display("FAIL fair_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
      checks++;
      if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
        $display("FAIL fair_resp: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
      checks++;
      if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
        $display("FAIL fair_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
      if (resp_valid_out != '0) begin
        idx = 0;
        for (int i = 0; i < N; i++) if (resp_valid_out[i]) idx = i;
        checks++;
        if ($countones(resp_valid_out) != 1 || resp_data_out !== 32'(idx*4 + 32'h100)) begin errors++;
          $display("FAIL fair_route: got v=%b d=%h, want one-hot with d=issuer*4+0x100", resp_valid_out, resp_data_out); end
      end
      if (c == 0) for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i*4));
      if (c == 20) req_valid_in = '0;
      #1;
      g = model_grant(req_valid_in);
      checks++;
      if (req_ready_out !== g) begin errors++;
        $display("FAIL fair_ready: got %b, want %b", req_ready_out, g); end
      if (c < 20) begin
        checks++;
        if (req_ready_out !== N'(1 << (gcount % N))) begin errors++;
          $display("FAIL fair_order: got %b, want %b", req_ready_out, N'(1 << (gcount % N))); end
        gcount++;
      end
    end
  endtask

  task automatic test_single();
    logic [N-1:0] g;
    logic granted = 1'b0;
    int saw = 0;
    int max_out = 0;
    lat = 2;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_in);
      checks++;
      if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
        $display("FAIL single_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
      checks++;
      if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
        $display("FAIL single_resp_model: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
      checks++;
      if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
        $display("FAIL single_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
      if (mem_valid_out) begin
        checks++;
        if (mem_req_out !== 32'h10) begin errors++;
          $display("FAIL single_addr: got %h, want 00000010", mem_req_out); end
      end
      if (resp_valid_out != '0) begin
        saw++;
        checks++;
        if (resp_valid_out !== 4'b0001 || resp_data_out !== 32'h110) begin errors++;
          $display("FAIL single_resp: got v=%b d=%h, want v=0001 d=00000110", resp_valid_out, resp_data_out); end
      end
      if (int'(outstanding_out) > max_out) max_out = int'(outstanding_out);
      if (c == 0) set_req(0, 1'b1, 32'h10);
      if (granted) set_req(0, 1'b0, 32'h0);
      #1;
      g = model_grant(req_valid_in);
      checks++;
      if (req_ready_out !== g) begin errors++;
        $display("FAIL single_ready: got %b, want %b", req_ready_out, g); end
      if (g[0]) granted = 1'b1;
    end
    checks++;
    if (saw != 1 || max_out != 1) begin errors++;
      $display("FAIL single_summary: got responses=%0d max_out=%0d, want 1 and 1", saw, max_out); end
  endtask

  task automatic test_interleaved();
    logic [N-1:0] g;
    logic [N-1:0]  iv [2];
    logic [DW-1:0] id [2];
    int phase = 0;
    int nresp = 0;
    iv[0] = 4'b1000; iv[1] = 4'b0001;
    id[0] = 32'h130; id[1] = 32'h140;
    lat = 2;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk_in);
      checks++;
      if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
        $display("FAIL inter_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
      checks++;
      if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
        $display("FAIL inter_resp_model: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
      checks++;
      if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
        $display("FAIL inter_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
      if (resp_valid_out != '0) begin
        if (nresp < 2) begin
          checks++;
          if (resp_valid_out !== iv[nresp] || resp_data_out !== id[nresp]) begin errors++;
            $display("FAIL inter_order: resp %0d got v=%b d=%h, want v=%b d=%h",
                     nresp, resp_valid_out, resp_data_out, iv[nresp], id[nresp]); end
        end
        nresp++;
      end
      if (c == 0) set_req(3, 1'b1, 32'h30);
      if (phase == 1) begin set_req(3, 1'b0, 32'h0); set_req(0, 1'b1, 32'h40); phase = 2; end
      else if (phase == 3) begin set_req(0, 1'b0, 32'h0); phase = 4; end
      #1;
      g = model_grant(req_valid_in);
      checks++;
      if (req_ready_out !== g) begin errors++;
        $display("FAIL inter_ready: got %b, want %b", req_ready_out, g); end
      if (phase == 0 && g[3]) phase = 1;
      if (phase == 2 && g[0]) phase = 3;
    end
    checks++;
    if (nresp != 2) begin errors++;
      $display("FAIL inter_count_resp: got %0d responses, want 2", nresp); end
  endtask

  task automatic test_full();
    logic [N-1:0] g;
    logic [N-1:0] hs_prev = '0;
    logic saw_full = 1'b0;
    int prev_out = 0;
    lat = 8;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk_in);
      checks++;
      if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
        $display("FAIL full_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
      checks++;
      if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
        $display("FAIL full_resp: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
      checks++;
      if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
        $display("FAIL full_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
      if (c == 0) begin set_req(1, 1'b1, $urandom); set_req(2, 1'b1, $urandom); end
      if (hs_prev[1]) set_req(1, 1'b1, $urandom);
      if (hs_prev[2]) set_req(2, 1'b1, $urandom);
      if (c == 34) req_valid_in = '0;
      #1;
      g = model_grant(req_valid_in);
      checks++;
      if (req_ready_out !== g) begin errors++;
        $display("FAIL full_ready: got %b, want %b", req_ready_out, g); end
      if (c < 4) begin
        checks++;
        if (req_ready_out == '0) begin errors++;
          $display("FAIL full_first_grants: cycle %0d got ready=%b, want a grant", c, req_ready_out); end
      end
      if (outstanding_out == 3'd4) begin
        saw_full = 1'b1;
        checks++;
        if (req_ready_out !== 4'b0000) begin errors++;
          $display("FAIL full_block: got ready=%b with 4 in flight, want 0000", req_ready_out); end
      end
      if (c < 34 && prev_out == 4 && outstanding_out == 3'd3) begin
        checks++;
        if (req_ready_out == '0) begin errors++;
          $display("FAIL full_resume: got ready=%b after count fell to 3, want a grant", req_ready_out); end
      end
      prev_out = int'(outstanding_out);
      hs_prev = g;
    end
    checks++;
    if (!saw_full) begin errors++;
      $display("FAIL full_reached: got saw_full=0, want outstanding 4 observed"); end
  endtask

  task automatic test_random();
    logic [N-1:0] g;
    logic [N-1:0] hs_prev;
    for (int r = 0; r < 3; r++) begin
      lat = $urandom_range(1, 4);
      hs_prev = '0;
      for (int c = 0; c < 150; c++) begin
        @(negedge clk_in);
        checks++;
        if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
          $display("FAIL rand_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
        checks++;
        if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
          $display("FAIL rand_resp: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
        checks++;
        if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
          $display("FAIL rand_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
        for (int i = 0; i < N; i++) begin
          if (c >= 138) set_req(i, 1'b0, 32'h0);
          else if (!req_valid_in[i] || hs_prev[i]) begin
            if ($urandom_range(0, 1) == 1) set_req(i, 1'b1, $urandom);
            else set_req(i, 1'b0, 32'h0);
          end
        end
        #1;
        g = model_grant(req_valid_in);
        checks++;
        if (req_ready_out !== g) begin errors++;
          $display("FAIL rand_ready: got %b, want %b", req_ready_out, g); end
        hs_prev = g;
      end
    end
  endtask

  task automatic test_orphan_reset();
    logic [N-1:0] g;
    logic [N-1:0] hs_prev = '0;
    for (int c = 0; c < 26; c++) begin
      @(negedge clk_in);
      checks++;
      if (mem_valid_out !== e_mv || mem_req_out !== e_mr) begin errors++;
        $display("FAIL orst_issue: got v=%b addr=%h, want v=%b addr=%h", mem_valid_out, mem_req_out, e_mv, e_mr); end
      checks++;
      if (resp_valid_out !== e_rv || resp_data_out !== e_rd) begin errors++;
        $display("FAIL orst_resp: got v=%b d=%h, want v=%b d=%h", resp_valid_out, resp_data_out, e_rv, e_rd); end
      checks++;
      if (outstanding_out !== e_out || err_out !== e_err) begin errors++;
        $display("FAIL orst_count: got out=%0d err=%b, want out=%0d err=%b", outstanding_out, err_out, e_out, e_err); end
      if (c < 6) begin
        checks++;
        if (resp_valid_out !== '0) begin errors++;
          $display("FAIL orphan_resp: got v=%b, want 0000", resp_valid_out); end
      end
      if (c == 0) orphan_req = 1'b1;
      if (c == 6) begin
        checks++;
        if (err_out !== 1'b1) begin errors++;
          $display("FAIL orphan_err: got %b, want 1", err_out); end
        lat = 8;
      end
      if (c >= 6 && c < 11)
        for (int i = 0; i < N; i++)
          if (!req_valid_in[i] || hs_prev[i]) set_req(i, 1'b1, $urandom);
      if (c == 11) begin
        #2;
        rst_in = 1'b0;
        #1;
        checks++;
        if ({req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out, outstanding_out, err_out} !== '0) begin
          errors++;
          $display("FAIL reset_async: ready=%b resp_v=%b data=%h mreq=%h mv=%b out=%0d err=%b, want all 0",
                   req_ready_out, resp_valid_out, resp_data_out, mem_req_out, mem_valid_out, outstanding_out, err_out);
        end
        repeat (2) @(negedge clk_in);
        rst_in = 1'b1;
        req_valid_in = '1;
        #1;
        checks++;
        if (req_ready_out !== 4'b0001) begin errors++;
          $display("FAIL reset_first_grant: got %b, want 0001", req_ready_out); end
        req_valid_in = '0;
      end
      #1;
      g = model_grant(req_valid_in);
      checks++;
      if (req_ready_out !== g) begin errors++;
        $display("FAIL orst_ready: got %b, want %b", req_ready_out, g); end
      hs_prev = g;
    end
    checks++;
    if (err_out !== 1'b1) begin errors++;
      $display("FAIL reset_late_orphan: got err=%b, want 1 after lost reads return", err_out); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_interleaved();
    test_full();
    test_random();
    test_orphan_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
